vga_pixel_scanner: RTL and testbench



---
 rtl/vga_pixel_scanner.sv | 115 +++++++++++
 tb/tb_vga_pixel_scanner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_scanner.sv
// Raster scanner: walks the VGA timing counters, issues linear VRAM read addresses,
// and realigns the 1-cycle-latency pixel data with delayed sync to drive the pins.
module vga_pixel_scanner #(
  parameter int           ACTIVE_COLUMNS = 640,
  parameter int           ACTIVE_ROWS    = 480,
  parameter int           H_FRONT        = 16,
  parameter int           H_SYNC         = 96,
  parameter int           H_BACK         = 48,
  parameter int           V_FRONT        = 10,
  parameter int           V_SYNC         = 2,
  parameter int           V_BACK         = 33,
  parameter int           ADDR_WIDTH     = 19,
  parameter int           DATA_WIDTH     = 1,
  parameter logic [11:0]  SAND_COLOR     = 12'hFC0,
  parameter logic [11:0]  BG_COLOR       = 12'h000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic [11:0]           rgb_o,
  output logic                  frame_start_o,
  output logic                  vblank_o
);

  localparam int H_TOTAL  = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = ACTIVE_COLUMNS + H_FRONT;
  localparam int HS_END   = ACTIVE_COLUMNS + H_FRONT + H_SYNC - 1;
  localparam int VS_START = ACTIVE_ROWS + V_FRONT;
  localparam int VS_END   = ACTIVE_ROWS + V_FRONT + V_SYNC - 1;
  localparam int LAST_PIX = ACTIVE_COLUMNS * ACTIVE_ROWS - 1;

  // Stage 0 state
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  frame_start_q, frame_start_d;
  logic                  vblank_q, vblank_d;
  // Stage 1 state
  logic                  active1_q, hs1_q, vs1_q;
  // Stage 2 state
  logic                  hsync_q, vsync_q;
  logic [11:0]           rgb_q, rgb_d;

  logic h_wrap, v_wrap, active0, hs0, vs0;

  always_comb begin
    h_wrap = (h_q == HW'(H_TOTAL - 1));
    v_wrap = (v_q == VW'(V_TOTAL - 1));
    h_d    = h_wrap ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + VW'(1);
    end

    active0 = (h_q < HW'(ACTIVE_COLUMNS)) && (v_q < VW'(ACTIVE_ROWS));
    hs0     = !((h_q >= HW'(HS_START)) && (h_q <= HW'(HS_END)));
    vs0     = !((v_q >= VW'(VS_START)) && (v_q <= VW'(VS_END)));

    // Running address replaces v*COLUMNS+h; it freezes during blanking.
    addr_d = addr_q;
    if (active0) begin
      addr_d = (addr_q == ADDR_WIDTH'(LAST_PIX)) ? '0 : addr_q + ADDR_WIDTH'(1);
    end

    frame_start_d = h_wrap && v_wrap;
    vblank_d      = (v_d >= VW'(ACTIVE_ROWS));

    rgb_d = 12'h000;
    if (active1_q) begin
      rgb_d = (data_i != '0) ? SAND_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
      active1_q     <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 12'h000;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
      active1_q     <= active0;
      hs1_q         <= hs0;
      vs1_q         <= vs0;
      hsync_q       <= hs1_q;
      vsync_q       <= vs1_q;
      rgb_q         <= rgb_d;
    end
  end

  assign addr_o        = addr_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign rgb_o         = rgb_q;
  assign frame_start_o = frame_start_q;
  assign vblank_o      = vblank_q;

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Bench for vga_pixel_scanner on a shrunken 15x10 raster (8x6 visible) so whole frames fit.
module tb_vga_pixel_scanner;

  localparam int AC = 8, AR = 6;
  localparam int HF = 2, HS = 3, HB = 2;
  localparam int VF = 1, VS = 2, VB = 1;
  localparam int HT = AC + HF + HS + HB;
  localparam int VT = AR + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int AW = 6;
  localparam int TARGET = AC + 1;
  localparam logic [11:0] SAND = 12'hFC0;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [0:0]    data_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic          hsync_o, vsync_o, frame_start_o, vblank_o;
  logic [11:0]   rgb_o;

  int n_checks = 0;
  int n_pass   = 0;

  vga_pixel_scanner #(
    .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .ADDR_WIDTH(AW), .DATA_WIDTH(1),
    .SAND_COLOR(SAND), .BG_COLOR(12'h000)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .addr_o(addr_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .rgb_o(rgb_o),
    .frame_start_o(frame_start_o), .vblank_o(vblank_o)
  );

  // Clock
  always #5 clk = ~clk;

  // VRAM model: one lit pixel at address TARGET, 1-cycle read latency.
  always @(posedge clk) data_i <= (addr_o == AW'(TARGET)) ? 1'b1 : 1'b0;

  typedef struct {
    int          cyc;
    logic        hs;
    logic        vs;
    int          addr;
    logic [11:0] rgb;
    logic        vb;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, k, act, exp);
  endtask

  // Reference model: closed-form outputs for counter cycle k after reset release.
  function automatic int hc(input int k); return k % HT; endfunction
  function automatic int vc(input int k); return (k / HT) % VT; endfunction
  function automatic bit act(input int k); return hc(k) < AC && vc(k) < AR; endfunction
  function automatic int exp_addr(input int k);
    int n;
    if (vc(k) >= AR) return 0;
    n = vc(k) * AC + ((hc(k) < AC) ? hc(k) : AC);
    return (n == AC * AR) ? 0 : n;
  endfunction
  function automatic logic exp_hs(input int k);
    if (k < 2) return 1'b1;
    return !(hc(k-2) >= AC + HF && hc(k-2) <= AC + HF + HS - 1);
  endfunction
  function automatic logic exp_vs(input int k);
    if (k < 2) return 1'b1;
    return !(vc(k-2) >= AR + VF && vc(k-2) <= AR + VF + VS - 1);
  endfunction
  function automatic logic [11:0] exp_rgb(input int k);
    if (k < 2) return 12'h000;
    return (act(k-2) && exp_addr(k-2) == TARGET) ? SAND : 12'h000;
  endfunction

  task automatic check_model(input int k);
    chk("addr",        k, 32'(addr_o),        32'(exp_addr(k)));
    chk("hsync",       k, 32'(hsync_o),       32'(exp_hs(k)));
    chk("vsync",       k, 32'(vsync_o),       32'(exp_vs(k)));
    chk("rgb",         k, 32'(rgb_o),         32'(exp_rgb(k)));
    chk("vblank",      k, 32'(vblank_o),      32'(vc(k) >= AR));
    chk("frame_start", k, 32'(frame_start_o), 32'(k > 0 && hc(k) == 0 && vc(k) == 0));
  endtask

  task automatic check_table(input int k);
    foreach (tbl[i]) begin
      if (tbl[i].cyc == k) begin
        chk("tbl_hsync",  k, 32'(hsync_o),       32'(tbl[i].hs));
        chk("tbl_vsync",  k, 32'(vsync_o),       32'(tbl[i].vs));
        chk("tbl_addr",   k, 32'(addr_o),        32'(tbl[i].addr));
        chk("tbl_rgb",    k, 32'(rgb_o),         32'(tbl[i].rgb));
        chk("tbl_vblank", k, 32'(vblank_o),      32'(tbl[i].vb));
        chk("tbl_fstart", k, 32'(frame_start_o), 32'(tbl[i].fs));
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hsync"},  -1, 32'(hsync_o),       32'(1));
    chk({tag, "_vsync"},  -1, 32'(vsync_o),       32'(1));
    chk({tag, "_rgb"},    -1, 32'(rgb_o),         32'(0));
    chk({tag, "_addr"},   -1, 32'(addr_o),        32'(0));
    chk({tag, "_fstart"}, -1, 32'(frame_start_o), 32'(0));
    chk({tag, "_vblank"}, -1, 32'(vblank_o),      32'(0));
  endtask

  // Driver: run from counter cycle 0 for n cycles, sampling 1 time unit after each negedge.
  task automatic run_cycles(input int n, input bit use_tbl);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check_model(k);
      if (use_tbl) check_table(k);
    end
  endtask

  initial begin
    // cyc, hs, vs, addr, rgb, vblank, frame_start (hand-computed)
    tbl.push_back('{0,   1'b1, 1'b1, 0,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{2,   1'b1, 1'b1, 2,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{8,   1'b1, 1'b1, 8,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{12,  1'b0, 1'b1, 8,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{14,  1'b0, 1'b1, 8,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{15,  1'b1, 1'b1, 8,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{16,  1'b1, 1'b1, 9,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{18,  1'b1, 1'b1, 11, 12'hFC0, 1'b0, 1'b0});
    tbl.push_back('{19,  1'b1, 1'b1, 12, 12'h000, 1'b0, 1'b0});
    tbl.push_back('{82,  1'b1, 1'b1, 47, 12'h000, 1'b0, 1'b0});
    tbl.push_back('{83,  1'b1, 1'b1, 0,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{90,  1'b1, 1'b1, 0,  12'h000, 1'b1, 1'b0});
    tbl.push_back('{106, 1'b1, 1'b1, 0,  12'h000, 1'b1, 1'b0});
    tbl.push_back('{107, 1'b1, 1'b0, 0,  12'h000, 1'b1, 1'b0});
    tbl.push_back('{136, 1'b1, 1'b0, 0,  12'h000, 1'b1, 1'b0});
    tbl.push_back('{137, 1'b1, 1'b1, 0,  12'h000, 1'b1, 1'b0});
    tbl.push_back('{149, 1'b0, 1'b1, 0,  12'h000, 1'b1, 1'b0});
    tbl.push_back('{150, 1'b1, 1'b1, 0,  12'h000, 1'b0, 1'b1});
    tbl.push_back('{151, 1'b1, 1'b1, 1,  12'h000, 1'b0, 1'b0});
    tbl.push_back('{168, 1'b1, 1'b1, 11, 12'hFC0, 1'b0, 1'b0});

    // Reset held for 5 cycles
    reset_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check_reset_vals("rst");
    end
    @(negedge clk);
    reset_i = 1'b0;
    #1;

    // Two full frames plus into frame three, ending at line 3 pixel 5
    run_cycles(2 * FRAME + 3 * HT + 5 + 1, 1'b1);

    // Mid-frame asynchronous reset, held 3 cycles
    #1;
    reset_i = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("rst_hold");
    reset_i = 1'b0;

    // Scan restarts identically after release
    run_cycles(FRAME + 20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
